// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the switch-and-button memory loader.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone
  } loader_state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NIBS       = DATA_W_DEF / 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, rise_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ, settle;

  assign differ = (sync2_q != level_q);
  // Level flips on the DEB_CYCLES-th consecutive differing sample.
  assign settle = differ && (cnt_q == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      rise_q  <= settle && sync2_q;
      if (settle) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else if (differ) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/mem_loader.sv
// Nibble-at-a-time program loader: assembles 16-bit words from SW presses and
// writes them to sequential memory addresses.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEB_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              button,
  input  logic [3:0]        SW,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        nib_idx,
  output logic [DATA_W-1:0] y
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        nib_q, nib_d;
  logic              we_q;
  logic              start_d;
  logic              start_edge;
  logic              press;
  logic              btn_level;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk       (clk),
    .reset     (reset),
    .raw       (button),
    .level     (btn_level),
    .rise_pulse(press)
  );

  assign start_edge = start && !start_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    nib_d   = nib_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d = StCollect;
          addr_d  = '0;
          word_d  = '0;
          nib_d   = '0;
        end
      end
      StCollect: begin
        // start_edge has priority; a coincident nibble is dropped.
        if (start_edge) begin
          state_d = StDone;
        end else if (press) begin
          word_d = {word_q[DATA_W-5:0], SW};
          nib_d  = nib_q + 2'd1;
          if (nib_q == 2'(NIBS - 1)) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (addr_q == '1) begin
          state_d = StDone;
        end else begin
          state_d = StCollect;
          addr_d  = addr_q + ADDR_W'(1);
          word_d  = '0;
          nib_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      nib_q   <= '0;
      we_q    <= 1'b0;
      start_d <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      nib_q   <= nib_d;
      we_q    <= (state_d == StWrite);
      start_d <= start;
    end
  end

  // Gate with reset so a pending strobe never shows during the reset cycle.
  assign mem_we    = we_q && !reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign busy      = (state_q == StCollect) || (state_q == StWrite);
  assign done      = (state_q == StDone);
  assign nib_idx   = nib_q;
  assign y         = busy ? word_q : DATA_W'(addr_q);

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: one default instance and one with ADDR_W=2.
module tb_mem_loader;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = DEB + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic        button = 1'b0, button2 = 1'b0;
  logic [3:0]  SW = 4'h0;

  logic        mem_we, mem_we2;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_addr2;
  logic [15:0] mem_wdata, mem_wdata2, y, y2;
  logic        busy, busy2, done, done2;
  logic [1:0]  nib_idx, nib_idx2;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  logic [17:0] exp2_q[$];
  logic        we_prev = 1'b0, we2_prev = 1'b0;

  mem_loader #(.ADDR_W(8), .DATA_W(16), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .start(start), .button(button), .SW(SW),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .nib_idx(nib_idx), .y(y)
  );

  mem_loader #(.ADDR_W(2), .DATA_W(16), .DEB_CYCLES(DEB)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .button(button2), .SW(SW),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .nib_idx(nib_idx2), .y(y2)
  );

  always #5 clk = ~clk;

  // Advance one cycle; any write strobe is popped from the scoreboard.
  task automatic tick();
    logic [23:0] e;
    logic [17:0] e2;
    @(posedge clk);
    #1;
    if (mem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dut1_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL dut1_write: got %h_%h, required %h_%h", mem_addr, mem_wdata,
                   e[23:16], e[15:0]);
        end
      end
      if (we_prev) begin
        bad++;
        $display("FAIL dut1_we_width: got 2 consecutive strobes, required 1");
      end
    end
    if (mem_we2) begin
      total++;
      if (exp2_q.size() == 0) begin
        bad++;
        $display("FAIL dut2_write: got addr=%h data=%h, required no write", mem_addr2,
                 mem_wdata2);
      end else begin
        e2 = exp2_q.pop_front();
        if ({mem_addr2, mem_wdata2} !== e2) begin
          bad++;
          $display("FAIL dut2_write: got %h_%h, required %h_%h", mem_addr2, mem_wdata2,
                   e2[17:16], e2[15:0]);
        end
      end
    end
    we_prev  = mem_we;
    we2_prev = mem_we2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start(input bit which);
    if (which) start2 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start2 = 1'b0;
    tick();
  endtask

  task automatic press(input bit which, input logic [3:0] v);
    SW = v;
    if (which) button2 = 1'b1; else button = 1'b1;
    ticks(HOLD);
    button = 1'b0;
    button2 = 1'b0;
    ticks(HOLD);
  endtask

  task automatic key_word(input bit which, input logic [7:0] a, input logic [15:0] w);
    if (which) exp2_q.push_back({a[1:0], w}); else exp_q.push_back({a, w});
    for (int i = 3; i >= 0; i--) press(which, w[i*4 +: 4]);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, nib_idx, y} !== 45'd0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h busy=%b done=%b nib=%0d y=%h, required all 0",
               mem_we, mem_addr, mem_wdata, busy, done, nib_idx, y);
    end
    total++;
    if ({mem_we2, busy2, done2, nib_idx2, y2} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs2: got busy=%b done=%b y=%h, required 0", busy2, done2, y2);
    end
  endtask

  task automatic test_single_word();
    press(1'b0, 4'h9);
    total++;
    if (nib_idx !== 2'd0) begin
      bad++;
      $display("FAIL idle_ignores_press: got nib=%0d, required 0", nib_idx);
    end
    pulse_start(1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_to_collect: got busy=%b, required 1", busy);
    end
    exp_q.push_back({8'h00, 16'h1234});
    press(1'b0, 4'h1);
    press(1'b0, 4'h2);
    total++;
    if (nib_idx !== 2'd2 || y !== 16'h0012) begin
      bad++;
      $display("FAIL partial_word: got nib=%0d y=%h, required 2 0012", nib_idx, y);
    end
    press(1'b0, 4'h3);
    press(1'b0, 4'h4);
    total++;
    if (exp_q.size() != 0 || nib_idx !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_word: got pending=%0d nib=%0d busy=%b done=%b, required 0 0 1 0",
               exp_q.size(), nib_idx, busy, done);
    end
  endtask

  task automatic test_two_words();
    do_reset();
    pulse_start(1'b0);
    key_word(1'b0, 8'h00, 16'hABCD);
    key_word(1'b0, 8'h01, 16'h0F0F);
    pulse_start(1'b0);
    total++;
    if (exp_q.size() != 0 || done !== 1'b1 || busy !== 1'b0 || y !== 16'h0002) begin
      bad++;
      $display("FAIL two_words: got pending=%0d done=%b busy=%b y=%h, required 0 1 0 0002",
               exp_q.size(), done, busy, y);
    end
  endtask

  task automatic test_bounce();
    pulse_start(1'b0);
    total++;
    if (nib_idx !== 2'd0 || y !== 16'h0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart: got nib=%0d y=%h busy=%b, required 0 0000 1", nib_idx, y, busy);
    end
    SW = 4'hC;
    for (int i = 0; i < 5; i++) begin
      button = 1'b1;
      ticks(2);
      button = 1'b0;
      ticks(2);
    end
    button = 1'b1;
    ticks(HOLD);
    button = 1'b0;
    ticks(HOLD);
    total++;
    if (nib_idx !== 2'd1 || y !== 16'h000C) begin
      bad++;
      $display("FAIL bounce: got nib=%0d y=%h, required 1 000c", nib_idx, y);
    end
  endtask

  task automatic test_partial();
    press(1'b0, 4'h5);
    pulse_start(1'b0);
    total++;
    if (done !== 1'b1 || y !== 16'h0000 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL partial_discard: got done=%b y=%h, required 1 0000", done, y);
    end
    press(1'b0, 4'h6);
    pulse_start(1'b0);
    key_word(1'b0, 8'h00, 16'h5A5A);
    total++;
    if (exp_q.size() != 0 || mem_addr !== 8'h01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_addr0: got pending=%0d addr=%h busy=%b, required 0 01 1",
               exp_q.size(), mem_addr, busy);
    end
  endtask

  task automatic test_same_cycle();
    press(1'b0, 4'h7);
    tick();
    SW = 4'h9;
    button = 1'b1;
    ticks(6);
    start = 1'b1;
    tick();
    total++;
    if (done !== 1'b1 || mem_wdata !== 16'h0007 || nib_idx !== 2'd1) begin
      bad++;
      $display("FAIL same_cycle: got done=%b word=%h nib=%0d, required 1 0007 1",
               done, mem_wdata, nib_idx);
    end
    start = 1'b0;
    button = 1'b0;
    ticks(HOLD);
  endtask

  task automatic test_no_wrap();
    pulse_start(1'b1);
    key_word(1'b1, 8'd0, 16'h1111);
    key_word(1'b1, 8'd1, 16'h2222);
    key_word(1'b1, 8'd2, 16'h3333);
    key_word(1'b1, 8'd3, 16'h4444);
    total++;
    if (exp2_q.size() != 0 || done2 !== 1'b1 || y2 !== 16'h0003) begin
      bad++;
      $display("FAIL no_wrap: got pending=%0d done=%b y=%h, required 0 1 0003",
               exp2_q.size(), done2, y2);
    end
    press(1'b1, 4'h8);
    total++;
    if (done2 !== 1'b1 || mem_addr2 !== 2'd3) begin
      bad++;
      $display("FAIL done_hold: got done=%b addr=%0d, required 1 3", done2, mem_addr2);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(1'b0);
    press(1'b0, 4'h1);
    press(1'b0, 4'h2);
    press(1'b0, 4'h3);
    total++;
    if (nib_idx !== 2'd3) begin
      bad++;
      $display("FAIL pre_reset: got nib=%0d, required 3", nib_idx);
    end
    button = 1'b1;
    ticks(2);
    reset = 1'b1;
    tick();
    total++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || nib_idx !== 2'd0 || y !== 16'h0000) begin
      bad++;
      $display("FAIL in_reset: got we=%b busy=%b nib=%0d y=%h, required 0 0 0 0000",
               mem_we, busy, nib_idx, y);
    end
    ticks(2);
    reset = 1'b0;
    ticks(HOLD);
    total++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, nib_idx, y} !== 45'd0 || exp_q.size() != 0)
    begin
      bad++;
      $display("FAIL post_reset_held: got busy=%b done=%b nib=%0d y=%h wd=%h, required all 0",
               busy, done, nib_idx, y, mem_wdata);
    end
    button = 1'b0;
    ticks(HOLD);
    pulse_start(1'b0);
    press(1'b0, 4'hE);
    total++;
    if (nib_idx !== 2'd1 || y !== 16'h000E) begin
      bad++;
      $display("FAIL fresh_press: got nib=%0d y=%h, required 1 000e", nib_idx, y);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_bounce();
    test_partial();
    test_same_cycle();
    test_no_wrap();
    test_reset_mid();
    ticks(4);
    total++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got pending=%0d/%0d, required 0/0",
               exp_q.size(), exp2_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
